// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ==========================================================================
// mem_wb_stage_pkg : encodings and limits shared by the MEM/WB stage files
// Rev 1.0
// ==========================================================================
package mem_wb_stage_pkg;

  localparam logic [1:0] MEM_READ      = 2'b01;
  localparam logic [1:0] MEM_WRITE     = 2'b10;
  localparam logic [1:0] MEM_NONE      = 2'b11;
  localparam logic [3:0] NO_REG        = 4'b1111;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // 2'b00 falls through to "no memory operation", same as MEM_NONE.
  function automatic logic is_mem_op(input logic [1:0] ctrl);
    return (ctrl == MEM_READ) || (ctrl == MEM_WRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ==========================================================================
// mem_wb_stage_if : EX-side, memory-bus and write-back signals of the stage
// Rev 1.0
// ==========================================================================
interface mem_wb_stage_if;

  logic        exValid;
  logic [15:0] exAluResult;
  logic [15:0] exStoreData;
  logic [3:0]  exWriteReg;
  logic [1:0]  exControlMem;

  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        memAck;
  logic [15:0] memRdata;

  logic        stall;
  logic [3:0]  writeBackReg;
  logic [15:0] writeBackData;
  logic        wbValid;
  logic        memErr;

  // master: the stage itself; slave: pipeline/memory environment around it
  modport master (
    input  exValid, exAluResult, exStoreData, exWriteReg, exControlMem,
    input  memAck, memRdata,
    output memReq, memWe, memAddr, memWdata,
    output stall, writeBackReg, writeBackData, wbValid, memErr
  );

  modport slave (
    output exValid, exAluResult, exStoreData, exWriteReg, exControlMem,
    output memAck, memRdata,
    input  memReq, memWe, memAddr, memWdata,
    input  stall, writeBackReg, writeBackData, wbValid, memErr
  );

endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ==========================================================================
// mem_wb_stage : MEM/WB pipeline stage with a two-state memory-access FSM.
//                Define MEM_WB_TIMEOUT_EN to add the 255-cycle access timeout.
// Rev 1.0
// ==========================================================================
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input wire logic       clk,
  input wire logic       rst,
  mem_wb_stage_if.master bus
);

  state_t      r_state;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [3:0]  r_wb_reg;
  logic [15:0] r_wb_data;
  logic        r_wb_valid;
  logic [3:0]  r_lat_reg;
  logic        r_lat_read;

  state_t      w_state_nxt;
  logic        w_mem_req_nxt;
  logic        w_mem_we_nxt;
  logic [15:0] w_mem_addr_nxt;
  logic [15:0] w_mem_wdata_nxt;
  logic [3:0]  w_wb_reg_nxt;
  logic [15:0] w_wb_data_nxt;
  logic        w_wb_valid_nxt;
  logic [3:0]  w_lat_reg_nxt;
  logic        w_lat_read_nxt;

`ifdef MEM_WB_TIMEOUT_EN
  logic [7:0]  r_tmo_cnt;
  logic        r_mem_err;
  logic        w_mem_err_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
      r_wb_reg    <= NO_REG;
      r_wb_data   <= 16'h0000;
      r_wb_valid  <= 1'b0;
      r_lat_reg   <= NO_REG;
      r_lat_read  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_wb_reg    <= w_wb_reg_nxt;
      r_wb_data   <= w_wb_data_nxt;
      r_wb_valid  <= w_wb_valid_nxt;
      r_lat_reg   <= w_lat_reg_nxt;
      r_lat_read  <= w_lat_read_nxt;
    end
  end

`ifdef MEM_WB_TIMEOUT_EN
  // Counter sits at zero in IDLE, so it is already clear on entry to ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= 8'd0;
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_mem_err_nxt;
      if ((r_state == ST_ACCESS) && !bus.memAck) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end else begin
        r_tmo_cnt <= 8'd0;
      end
    end
  end
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_wb_reg_nxt    = r_wb_reg;
    w_wb_data_nxt   = r_wb_data;
    w_wb_valid_nxt  = r_wb_valid;
    w_lat_reg_nxt   = r_lat_reg;
    w_lat_read_nxt  = r_lat_read;
`ifdef MEM_WB_TIMEOUT_EN
    w_mem_err_nxt   = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        w_wb_reg_nxt   = NO_REG;
        w_wb_valid_nxt = 1'b0;
        if (bus.exValid) begin
          if (is_mem_op(bus.exControlMem)) begin
            w_state_nxt     = ST_ACCESS;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = (bus.exControlMem == MEM_WRITE);
            w_mem_addr_nxt  = bus.exAluResult;
            w_mem_wdata_nxt = bus.exStoreData;
            w_lat_reg_nxt   = bus.exWriteReg;
            w_lat_read_nxt  = (bus.exControlMem == MEM_READ);
          end else begin
            w_wb_reg_nxt   = bus.exWriteReg;
            w_wb_data_nxt  = bus.exAluResult;
            w_wb_valid_nxt = (bus.exWriteReg != NO_REG);
          end
        end
      end

      ST_ACCESS: begin
        // Bus outputs hold and ex* is ignored until the access resolves.
        if (bus.memAck) begin
          w_state_nxt   = ST_IDLE;
          w_mem_req_nxt = 1'b0;
          if (r_lat_read) begin
            w_wb_reg_nxt   = r_lat_reg;
            w_wb_data_nxt  = bus.memRdata;
            w_wb_valid_nxt = (r_lat_reg != NO_REG);
          end else begin
            w_wb_reg_nxt   = NO_REG;
            w_wb_valid_nxt = 1'b0;
          end
        end
`ifdef MEM_WB_TIMEOUT_EN
        else if (r_tmo_cnt == TIMEOUT_LIMIT) begin
          w_state_nxt    = ST_IDLE;
          w_mem_req_nxt  = 1'b0;
          w_mem_err_nxt  = 1'b1;
          w_wb_reg_nxt   = NO_REG;
          w_wb_valid_nxt = 1'b0;
        end
`endif
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.stall         = (r_state == ST_ACCESS);
  assign bus.memReq        = r_mem_req;
  assign bus.memWe         = r_mem_we;
  assign bus.memAddr       = r_mem_addr;
  assign bus.memWdata      = r_mem_wdata;
  assign bus.writeBackReg  = r_wb_reg;
  assign bus.writeBackData = r_wb_data;
  assign bus.wbValid       = r_wb_valid;
`ifdef MEM_WB_TIMEOUT_EN
  assign bus.memErr        = r_mem_err;
`else
  assign bus.memErr        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ==========================================================================
// tb_mem_wb_stage : directed + randomized transaction checks of mem_wb_stage
// Rev 1.0
// ==========================================================================
module tb_mem_wb_stage;

  localparam logic [3:0] NONE_REG = 4'hF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;
  logic [15:0] exp_wb_data;

  mem_wb_stage_if bus();

  mem_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [1:0] ctrl, input logic [3:0] rg,
                          input logic [15:0] alu, input logic [15:0] sd);
    bus.exValid      = v;
    bus.exControlMem = ctrl;
    bus.exWriteReg   = rg;
    bus.exAluResult  = alu;
    bus.exStoreData  = sd;
  endtask

  task automatic drive_garbage();
    drive_ex(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic alu_op(input logic [1:0] ctrl, input logic [3:0] rg, input logic [15:0] data);
    drive_ex(1'b1, ctrl, rg, data, 16'($urandom));
    bus.memAck   = 1'($urandom_range(0, 1));
    bus.memRdata = 16'($urandom);
    tick();
    exp_wb_data = data;
    chk("alu_stall", 32'(bus.stall), 32'(1'b0));
    chk("alu_memreq", 32'(bus.memReq), 32'(1'b0));
    chk("alu_wbreg", 32'(bus.writeBackReg), 32'(rg));
    chk("alu_wbdata", 32'(bus.writeBackData), 32'(data));
    chk("alu_wbvalid", 32'(bus.wbValid), 32'(rg != NONE_REG));
    chk("alu_memerr", 32'(bus.memErr), 32'(1'b0));
  endtask

  task automatic idle_op();
    drive_ex(1'b0, 2'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
    bus.memAck   = 1'($urandom_range(0, 1));
    bus.memRdata = 16'($urandom);
    tick();
    chk("idle_stall", 32'(bus.stall), 32'(1'b0));
    chk("idle_wbreg", 32'(bus.writeBackReg), 32'(NONE_REG));
    chk("idle_wbvalid", 32'(bus.wbValid), 32'(1'b0));
    chk("idle_wbdata", 32'(bus.writeBackData), 32'(exp_wb_data));
    chk("idle_memerr", 32'(bus.memErr), 32'(1'b0));
  endtask

  // Memory op acknowledged on ACCESS cycle ncyc; optionally hold an ALU op upstream.
  task automatic mem_op(input bit wr, input logic [3:0] rg, input logic [15:0] addr,
                        input logic [15:0] sd, input int ncyc, input logic [15:0] rdata,
                        input bit hold, input logic [3:0] h_reg, input logic [15:0] h_data);
    drive_ex(1'b1, wr ? 2'b10 : 2'b01, rg, addr, sd);
    bus.memAck   = 1'($urandom_range(0, 1));
    bus.memRdata = 16'($urandom);
    tick();
    for (int k = 1; k <= ncyc; k++) begin
      chk("acc_stall", 32'(bus.stall), 32'(1'b1));
      chk("acc_memreq", 32'(bus.memReq), 32'(1'b1));
      chk("acc_memaddr", 32'(bus.memAddr), 32'(addr));
      chk("acc_memwe", 32'(bus.memWe), 32'(wr));
      chk("acc_memwdata", 32'(bus.memWdata), 32'(sd));
      chk("acc_wbvalid", 32'(bus.wbValid), 32'(1'b0));
      chk("acc_wbreg", 32'(bus.writeBackReg), 32'(NONE_REG));
      chk("acc_memerr", 32'(bus.memErr), 32'(1'b0));
      if (hold) drive_ex(1'b1, 2'b11, h_reg, h_data, 16'($urandom));
      else      drive_garbage();
      bus.memAck   = (k == ncyc);
      bus.memRdata = (k == ncyc) ? rdata : 16'($urandom);
      tick();
    end
    bus.memAck = 1'b0;
    chk("done_stall", 32'(bus.stall), 32'(1'b0));
    chk("done_memreq", 32'(bus.memReq), 32'(1'b0));
    chk("done_memerr", 32'(bus.memErr), 32'(1'b0));
    if (!wr) begin
      exp_wb_data = rdata;
      chk("ld_wbreg", 32'(bus.writeBackReg), 32'(rg));
      chk("ld_wbdata", 32'(bus.writeBackData), 32'(rdata));
      chk("ld_wbvalid", 32'(bus.wbValid), 32'(rg != NONE_REG));
    end else begin
      chk("st_wbreg", 32'(bus.writeBackReg), 32'(NONE_REG));
      chk("st_wbvalid", 32'(bus.wbValid), 32'(1'b0));
      chk("st_wbdata", 32'(bus.writeBackData), 32'(exp_wb_data));
    end
  endtask

  initial begin
    drive_ex(1'b0, 2'b11, NONE_REG, 16'h0000, 16'h0000);
    bus.memAck   = 1'b0;
    bus.memRdata = 16'h0000;
    rst = 1'b1;
    tick();
    tick();
    exp_wb_data = 16'h0000;
    chk("rst_memreq", 32'(bus.memReq), 32'(1'b0));
    chk("rst_memwe", 32'(bus.memWe), 32'(1'b0));
    chk("rst_memaddr", 32'(bus.memAddr), 32'h0);
    chk("rst_memwdata", 32'(bus.memWdata), 32'h0);
    chk("rst_wbreg", 32'(bus.writeBackReg), 32'(NONE_REG));
    chk("rst_wbdata", 32'(bus.writeBackData), 32'h0);
    chk("rst_wbvalid", 32'(bus.wbValid), 32'(1'b0));
    chk("rst_memerr", 32'(bus.memErr), 32'(1'b0));
    chk("rst_stall", 32'(bus.stall), 32'(1'b0));
    rst = 1'b0;

    // ALU pass-through, control 00 aliasing to none, and a bubble
    alu_op(2'b11, 4'd3, 16'h1234);
    alu_op(2'b00, 4'd7, 16'hA5A5);
    alu_op(2'b11, NONE_REG, 16'h0F0F);
    idle_op();

    // Load acked on third ACCESS cycle
    mem_op(1'b0, 4'd5, 16'h8000, 16'h1111, 3, 16'hBEEF, 1'b0, 4'd0, 16'h0);
    // Store acked after one cycle with an ALU op held behind it
    mem_op(1'b1, 4'd2, 16'h0040, 16'h00FF, 1, 16'h7777, 1'b1, 4'd9, 16'hCAFE);
    alu_op(2'b11, 4'd9, 16'hCAFE);
    // Load into NO_REG produces no write-back
    mem_op(1'b0, NONE_REG, 16'h0100, 16'h0, 2, 16'h4321, 1'b0, 4'd0, 16'h0);
    idle_op();

    // Reset in the second ACCESS cycle, then a stray ack
    drive_ex(1'b1, 2'b01, 4'd6, 16'h2222, 16'h3333);
    tick();
    drive_garbage();
    bus.memAck = 1'b0;
    tick();
    chk("rma_stall_pre", 32'(bus.stall), 32'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_wb_data = 16'h0000;
    chk("rma_memreq", 32'(bus.memReq), 32'(1'b0));
    chk("rma_stall", 32'(bus.stall), 32'(1'b0));
    chk("rma_wbreg", 32'(bus.writeBackReg), 32'(NONE_REG));
    chk("rma_wbvalid", 32'(bus.wbValid), 32'(1'b0));
    chk("rma_wbdata", 32'(bus.writeBackData), 32'h0);
    drive_ex(1'b0, 2'b01, 4'd6, 16'h2222, 16'h3333);
    bus.memAck   = 1'b1;
    bus.memRdata = 16'h9999;
    tick();
    bus.memAck = 1'b0;
    chk("stray_wbvalid", 32'(bus.wbValid), 32'(1'b0));
    chk("stray_wbreg", 32'(bus.writeBackReg), 32'(NONE_REG));
    chk("stray_wbdata", 32'(bus.writeBackData), 32'h0);
    chk("stray_stall", 32'(bus.stall), 32'(1'b0));

`ifdef MEM_WB_TIMEOUT_EN
    drive_ex(1'b1, 2'b01, 4'd4, 16'h5000, 16'h0);
    tick();
    for (int k = 1; k <= 256; k++) begin
      chk("tmo_stall", 32'(bus.stall), 32'(1'b1));
      chk("tmo_memerr_low", 32'(bus.memErr), 32'(1'b0));
      drive_garbage();
      bus.memAck = 1'b0;
      tick();
    end
    chk("tmo_memerr", 32'(bus.memErr), 32'(1'b1));
    chk("tmo_stall_end", 32'(bus.stall), 32'(1'b0));
    chk("tmo_memreq", 32'(bus.memReq), 32'(1'b0));
    chk("tmo_wbvalid", 32'(bus.wbValid), 32'(1'b0));
    chk("tmo_wbreg", 32'(bus.writeBackReg), 32'(NONE_REG));
    idle_op();
    mem_op(1'b0, 4'd8, 16'h5004, 16'h0, 256, 16'hD00D, 1'b0, 4'd0, 16'h0);
`else
    mem_op(1'b0, 4'd8, 16'h5004, 16'h0, 300, 16'hD00D, 1'b0, 4'd0, 16'h0);
`endif

    for (int i = 0; i < 200; i++) begin
      int kind;
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: idle_op();
        1: alu_op($urandom_range(0, 1) ? 2'b11 : 2'b00, 4'($urandom), 16'($urandom));
        2: mem_op(1'b0, 4'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(1, 6)), 16'($urandom), 1'b0, 4'd0, 16'h0);
        3: mem_op(1'b1, 4'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(1, 6)), 16'($urandom), 1'b0, 4'd0, 16'h0);
        default: begin
          logic [3:0]  h_reg;
          logic [15:0] h_data;
          h_reg  = 4'($urandom);
          h_data = 16'($urandom);
          mem_op(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 16'($urandom),
                 int'($urandom_range(1, 6)), 16'($urandom), 1'b1, h_reg, h_data);
          alu_op(2'b11, h_reg, h_data);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk (1-bit, rising edge) and rst (1-bit, active-high, synchronous).
REQ-002 Ports SHALL be, listed as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- exValid  in  1  EX result present
- exAluResult  in  16  ALU result / memory address
- exStoreData  in  16  store data
- exWriteReg  in  4  destination register, 4'b1111 = none
- exControlMem  in  2  01 read, 10 write, 11 none
- memReq  out  1  memory request
- memWe  out  1  1 = write
- memAddr  out  16  memory address
- memWdata  out  16  write data
- memAck  in  1  access complete, rdata valid
- memRdata  in  16  read data
- stall  out  1  hold upstream stages
- writeBackReg  out  4  register-file write index, 4'b1111 = none
- writeBackData  out  16  register-file write data
- wbValid  out  1  write-back is real
- memErr  out  1  access timeout pulse

Function
REQ-003 The FSM SHALL have exactly two states: IDLE and ACCESS.
REQ-004 In IDLE with exValid=1 and exControlMem=11, the next edge SHALL set writeBackReg=exWriteReg, writeBackData=exAluResult, wbValid=(exWriteReg!=4'b1111), and remain in IDLE; this gives 1-cycle latency.
REQ-005 In IDLE with exValid=0, the next edge SHALL set writeBackReg=4'b1111, wbValid=0, and leave writeBackData unchanged.
REQ-006 In IDLE with exValid=1 and exControlMem in {01,10}, the next edge SHALL enter ACCESS, set memReq=1, memAddr=exAluResult, memWe=(exControlMem==10), memWdata=exStoreData, latch exWriteReg and the read/write kind, and set writeBackReg=4'b1111 and wbValid=0.
REQ-007 exControlMem=00 SHALL be treated as 11.
REQ-008 The read/write decision SHALL come from exControlMem only; memToReg SHALL NOT be an input.
REQ-009 stall SHALL be a combinational output equal to (state==ACCESS); it SHALL be 0 in IDLE.
REQ-010 In ACCESS, memReq, memWe, memAddr and memWdata SHALL remain stable until memAck is sampled high, and all ex* inputs SHALL be ignored.
REQ-011 On the edge at which memAck=1 is sampled in ACCESS, the block SHALL:
- drop memReq and return to IDLE;
- for a read, set writeBackReg=latched reg, writeBackData=memRdata, and wbValid=(reg!=4'b1111);
- for a write, set writeBackReg=4'b1111 and wbValid=0.
REQ-012 The instruction held upstream during ACCESS SHALL be accepted in the first IDLE cycle after the access completes (one bubble per memory access).
REQ-013 memAck while in IDLE SHALL be ignored.
REQ-014 writeBackReg, writeBackData and wbValid SHALL all be registered outputs.

Reset
REQ-015 rst=1 SHALL force, at the next edge: state=IDLE, memReq=0, memWe=0, memAddr=0, memWdata=0, writeBackReg=4'b1111, writeBackData=0, wbValid=0, memErr=0, and timeout counter=0.
REQ-016 Reset during ACCESS SHALL abandon the access with no write-back, and memReq SHALL be low after that edge.

Configuration
REQ-017 With MEM_WB_TIMEOUT_EN defined, the block SHALL include an 8-bit counter that clears on entry to ACCESS and increments each ACCESS cycle without memAck.
REQ-018 With MEM_WB_TIMEOUT_EN defined, if the counter reaches 255 without memAck, the next edge SHALL return to IDLE, drop memReq, pulse memErr=1 for one cycle, and suppress the write-back (writeBackReg=4'b1111, wbValid=0).
REQ-019 With MEM_WB_TIMEOUT_EN defined, memAck and the timeout in the same cycle SHALL resolve as memAck (normal completion, memErr=0).
REQ-020 Without MEM_WB_TIMEOUT_EN, there SHALL be no counter, memErr SHALL be tied to 0, and ACCESS SHALL wait indefinitely.

Structure
REQ-021 A shared package/header SHALL hold:
- the exControlMem encodings MEM_READ=2'b01, MEM_WRITE=2'b10, MEM_NONE=2'b11;
- NO_REG=4'b1111;
- the state encodings;
- TIMEOUT_LIMIT=255.
REQ-022 The block SHALL be a single module with no sub-modules.

Verification
REQ-023 ALU pass-through: exValid=1, exControlMem=11, exWriteReg=3, exAluResult=16'h1234 -> next cycle writeBackReg=3, writeBackData=16'h1234, wbValid=1, stall=0.
REQ-024 Load with 3-cycle ack: exControlMem=01, exAluResult=16'h8000, exWriteReg=5; memAck on the 3rd ACCESS cycle with memRdata=16'hBEEF -> memReq=1, memAddr=16'h8000, memWe=0, stall=1 for 3 cycles; then writeBackReg=5, writeBackData=16'hBEEF, wbValid=1.
REQ-025 Store: exControlMem=10, exAluResult=16'h0040, exStoreData=16'h00FF, ack after 1 cycle -> memWe=1, memWdata=16'h00FF, no write-back (writeBackReg=4'b1111), and the next held instruction is written back 2 cycles after ack.
REQ-026 Reset mid-access: assert rst in the 2nd ACCESS cycle -> after that edge memReq=0, state=IDLE, writeBackReg=4'b1111, and a later stray memAck causes no write-back.
REQ-027 Timeout (MEM_WB_TIMEOUT_EN): load with memAck never asserted -> memErr=1 for exactly one cycle after 256 ACCESS cycles, then IDLE with wbValid=0; with memAck on cycle 256 instead -> normal write-back and memErr=0.
